fa16_pipe: RTL and testbench



---
 rtl/fa16_pipe.sv | 89 ++++++++
 tb/tb_fa16_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fa16_pipe.sv
// rtl/fa16_pipe.sv - two-stage pipelined 16-bit adder, valid/ready on both sides
module fa16_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] s,
  output logic        cout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [7:0]  r_lo_sum;
  logic        r_lo_c;
  logic [7:0]  r_a_hi;
  logic [7:0]  r_b_hi;
  logic        r_s1_valid;

  logic [15:0] r_s;
  logic        r_cout;
  logic        r_ovf;
  logic        r_s2_valid;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_in_xfer;
  logic [8:0]  w_lo;
  logic [8:0]  w_hi0;
  logic [8:0]  w_hi1;
  logic [8:0]  w_hi_sel;
  logic        w_ovf;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_in_xfer = in_valid && w_s1_adv;

  assign w_lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};

  // Both high-byte sums are formed up front; the low-byte carry only picks one.
  assign w_hi0    = {1'b0, r_a_hi} + {1'b0, r_b_hi};
  assign w_hi1    = w_hi0 + 9'd1;
  assign w_hi_sel = r_lo_c ? w_hi1 : w_hi0;
  assign w_ovf    = (r_a_hi[7] == r_b_hi[7]) && (w_hi_sel[7] != r_a_hi[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_lo_sum   <= 8'd0;
      r_lo_c     <= 1'b0;
      r_a_hi     <= 8'd0;
      r_b_hi     <= 8'd0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (w_in_xfer) begin
        r_lo_sum <= w_lo[7:0];
        r_lo_c   <= w_lo[8];
        r_a_hi   <= a[15:8];
        r_b_hi   <= b[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s        <= 16'd0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s    <= {w_hi_sel[7:0], r_lo_sum};
        r_cout <= w_hi_sel[8];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_s2_valid;

endmodule

// File: tb/tb_fa16_pipe.sv
// tb/tb_fa16_pipe.sv - self-checking bench for fa16_pipe
module tb_fa16_pipe;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  fa16_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
    e.s    = full[15:0];
    e.cout = full[16];
    e.ovf  = (ia[15] == ib[15]) && (full[15] != ia[15]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop plus hold-stability check on every stalled cycle.
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out   = 18'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {14'd0, s, cout, ovf}, {14'd0, prev_out});
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got s=%0h with empty scoreboard", s);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_s", {16'd0, s}, {16'd0, e.s});
          chk("sb_cout", {31'd0, cout}, {31'd0, e.cout});
          chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {s, cout, ovf};
    end
  end

  // One cycle: inputs applied just after a rising edge, transfer decided at the falling edge.
  task automatic cyc(input logic v, input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                     input logic ordy, input exp_t e, output logic acc);
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    @(negedge clk);
    acc = rst_n && v && in_ready;
    if (acc) sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    exp_t e;
    e = model(16'd0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 16'd0, 1'b0, ordy, e, acc);
  endtask

  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                      input exp_t e, input logic ordy);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cyc(1'b1, ia, ib, ic, ordy, e, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 20) begin
      idle(1'b1);
      t++;
    end
    chk("drain_empty", sbq.size(), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic        acc;
    int          n0;
    int          naccept;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    exp_t        e;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", {16'd0, s}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with latency checks
    for (int i = 0; i < 6; i++) begin
      e.s = vecs[i].s; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      send(vecs[i].a, vecs[i].b, vecs[i].cin, e, 1'b1);
      chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
      idle(1'b1);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_result", {15'd0, s, cout, ovf}, {15'd0, vecs[i].s, vecs[i].cout, vecs[i].ovf});
      idle(1'b1);
      chk("vec_drained", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back stream of 8
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      cyc(1'b1, ra, rb, rc, 1'b1, model(ra, rb, rc), acc);
      chk("stream_in_ready", {31'd0, acc}, 32'd1);
    end
    idle(1'b1);
    chk("stream_no_bubble", n_out - n0, 32'd7);
    idle(1'b1);
    chk("stream_count", n_out - n0, 32'd8);
    chk("stream_sb_empty", sbq.size(), 32'd0);

    // Backpressure: 4 cycles of out_ready=0, then release
    n0 = n_out;
    naccept = 0;
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      cyc(1'b1, ra, rb, rc, 1'b0, model(ra, rb, rc), acc);
      if (acc) naccept++;
      if (i >= 2) chk("bp_in_ready_low", {31'd0, acc}, 32'd0);
    end
    chk("bp_accepts", naccept, 32'd2);
    chk("bp_no_output", n_out - n0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      cyc(1'b1, ra, rb, rc, 1'b1, model(ra, rb, rc), acc);
      chk("bp_resume", {31'd0, acc}, 32'd1);
    end
    in_valid = 1'b0;
    drain();
    chk("bp_total", n_out - n0, 32'd6);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), ra, rb, rc, 1'($urandom_range(0, 3) != 0),
          model(ra, rb, rc), acc);
      if (i == 150) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_s", {16'd0, s}, 32'd0);
        chk("mid_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        sbq.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          idle(1'b1);
          chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        n0 = n_out;
        send(16'h0001, 16'h0002, 1'b0, model(16'h0001, 16'h0002, 1'b0), 1'b1);
        idle(1'b1);
        chk("post_rst_first_s", {16'd0, s}, 32'h0003);
        drain();
        chk("post_rst_first_count", n_out - n0, 32'd1);
      end
    end
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
